wdog_timer_core: RTL and testbench

//  Watchdog counter/control stage directly downstream of the watchdog register decode.

---
 rtl/wdog_pkg.sv | 25 ++
 rtl/wdog_down_counter.sv | 38 +++
 rtl/wdog_timer_core.sv | 230 +++++++++++++++++++++++
 tb/tb_wdog_timer_core.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wdog_pkg.sv
// -----------------------------------------------------------------------------
// wdog_pkg
// Shared definitions for the watchdog counter/control stage: register address
// map, FSM state encoding and the key that unlocks the optional LOCK register
// (present only when the design is built with WDOG_LOCK_EN defined).
// -----------------------------------------------------------------------------
package wdog_pkg;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_COUNT    = 2'd1,
      ST_INT_PEND = 2'd2,
      ST_RST_OUT  = 2'd3
   } wdog_state_t;

   localparam int unsigned REG_STATUS = 32'h0;
   localparam int unsigned REG_LOAD   = 32'h1;
   localparam int unsigned REG_CTRL   = 32'h2;
   localparam int unsigned REG_INTCLR = 32'h3;
   localparam int unsigned REG_VALUE  = 32'h4;
   localparam int unsigned REG_LOCK   = 32'hC;

   localparam logic [31:0] LOCK_KEY = 32'h1ACCE551;

endpackage

// File: rtl/wdog_down_counter.sv
// -----------------------------------------------------------------------------
// wdog_down_counter
// WIDTH-bit loadable down counter used as the watchdog timeout counter.
// Load has priority over decrement. Resets to all-ones.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   load load_val this cycle
//   load_val in   value to load
//   dec      in   decrement by one this cycle
//   count    out  current count
//   at_one   out  count equals one (next expiring decrement)
// -----------------------------------------------------------------------------
module wdog_down_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             at_one
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '1;
      end else if (load) begin
         count <= load_val;
      end else if (dec) begin
         count <= count - WIDTH'(1);
      end
   end

   assign at_one = (count == WIDTH'(1));

endmodule

// File: rtl/wdog_timer_core.sv
// -----------------------------------------------------------------------------
// wdog_timer_core
// Watchdog counter/control stage. Holds LOAD/CTRL registers, counts down on
// TICK, raises WDOG_INT on first expiry and pulses WDOG_RST on a second
// unserviced expiry (when RESEN is set). Registered readback with one cycle
// latency.
// Optional feature: define WDOG_LOCK_EN to add the LOCK register at 0xC.
// Ports:
//   CLK       in   system clock
//   RESETn    in   asynchronous active-low reset
//   TICK      in   count-enable strobe
//   KICK      in   service pulse (reload, clear interrupt)
//   WRITE     in   register write strobe
//   ADDR      in   register address
//   WDATA     in   write data
//   RDATA     out  registered read data
//   WDOG_INT  out  interrupt level, held until serviced
//   WDOG_RST  out  reset request pulse, RST_PULSE cycles
// -----------------------------------------------------------------------------
module wdog_timer_core
   import wdog_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int ADDR_W    = 4,
   parameter int RST_PULSE = 16
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              TICK,
   input  logic              KICK,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [31:0]       WDATA,
   output logic [31:0]       RDATA,
   output logic              WDOG_INT,
   output logic              WDOG_RST
);

   localparam int PW = $clog2(RST_PULSE + 1);

   // A LOAD value of zero would never expire; it is stored as one.
   function automatic logic [WIDTH-1:0] sanitize_load(input logic [WIDTH-1:0] v);
      return (v == '0) ? WIDTH'(1) : v;
   endfunction

   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      logic [31:0] r;
      r = '0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   wdog_state_t      state, state_nxt;
   logic [WIDTH-1:0] load_reg;
   logic [WIDTH-1:0] count;
   logic             at_one;
   logic             en, resen;
   logic             int_nxt;
   logic             reload, cnt_dec;
   logic [PW-1:0]    pulse_cnt;
   logic             pulse_done;
   logic             wr_ok;
   logic             sel_load, sel_ctrl, sel_intclr;
   logic             service;
   logic [31:0]      rdata_nxt;

`ifdef WDOG_LOCK_EN
   logic locked;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         locked <= 1'b0;
      end else if (WRITE && (ADDR == ADDR_W'(REG_LOCK))) begin
         locked <= (WDATA != LOCK_KEY);
      end
   end

   assign wr_ok = !locked;
`else
   assign wr_ok = 1'b1;
`endif

   assign sel_load   = WRITE && wr_ok && (ADDR == ADDR_W'(REG_LOAD));
   assign sel_ctrl   = WRITE && wr_ok && (ADDR == ADDR_W'(REG_CTRL));
   assign sel_intclr = WRITE && wr_ok && (ADDR == ADDR_W'(REG_INTCLR));
   assign service    = KICK || sel_intclr;
   assign pulse_done = (state == ST_RST_OUT) && (pulse_cnt == PW'(RST_PULSE - 1));

   // Register file
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         load_reg <= '1;
         en       <= 1'b0;
         resen    <= 1'b0;
      end else begin
         if (sel_load) begin
            load_reg <= sanitize_load(WDATA[WIDTH-1:0]);
         end
         if (sel_ctrl) begin
            en    <= WDATA[0];
            resen <= WDATA[1];
         end
      end
   end

   // A LOAD write reloads with the value being written, so the counter and
   // LOAD agree from the next cycle on.
   wdog_down_counter #(.WIDTH(WIDTH)) u_counter (
      .clk      (CLK),
      .rst_n    (RESETn),
      .load     (reload || sel_load),
      .load_val (sel_load ? sanitize_load(WDATA[WIDTH-1:0]) : load_reg),
      .dec      (cnt_dec),
      .count    (count),
      .at_one   (at_one)
   );

   // FSM state register
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state <= ST_DISABLED;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state. Service beats a LOAD write, which beats expiry.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_DISABLED: begin
            if (en) state_nxt = ST_COUNT;
         end
         ST_COUNT: begin
            if (!en) begin
               state_nxt = ST_DISABLED;
            end else if (!service && !sel_load && TICK && at_one) begin
               state_nxt = ST_INT_PEND;
            end
         end
         ST_INT_PEND: begin
            if (!en) begin
               state_nxt = ST_DISABLED;
            end else if (service) begin
               state_nxt = ST_COUNT;
            end else if (!sel_load && TICK && at_one && resen) begin
               state_nxt = ST_RST_OUT;
            end
         end
         ST_RST_OUT: begin
            if (pulse_done) state_nxt = en ? ST_COUNT : ST_DISABLED;
         end
         default: state_nxt = ST_DISABLED;
      endcase
   end

   // FSM outputs: counter control and interrupt level
   always_comb begin
      int_nxt = WDOG_INT;
      reload  = 1'b0;
      cnt_dec = 1'b0;
      case (state)
         ST_DISABLED: begin
            reload = en || service;
         end
         ST_COUNT, ST_INT_PEND: begin
            if (!en) begin
               int_nxt = 1'b0;
               reload  = service;
            end else if (service) begin
               int_nxt = 1'b0;
               reload  = 1'b1;
            end else if (!sel_load && TICK) begin
               if (at_one) begin
                  int_nxt = 1'b1;
                  reload  = 1'b1;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         ST_RST_OUT: begin
            if (pulse_done) begin
               int_nxt = 1'b0;
               reload  = 1'b1;
            end
         end
         default: begin
            int_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         WDOG_INT  <= 1'b0;
         pulse_cnt <= '0;
      end else begin
         WDOG_INT  <= int_nxt;
         pulse_cnt <= (state == ST_RST_OUT) ? pulse_cnt + PW'(1) : '0;
      end
   end

   // Derived from state so an asynchronous reset drops it immediately.
   assign WDOG_RST = (state == ST_RST_OUT);

   // Read mux
   always_comb begin
      rdata_nxt = '0;
      case (ADDR)
         ADDR_W'(REG_STATUS): rdata_nxt = {29'b0, WDOG_RST, WDOG_INT, en};
         ADDR_W'(REG_LOAD):   rdata_nxt = zext(load_reg);
         ADDR_W'(REG_CTRL):   rdata_nxt = {30'b0, resen, en};
         ADDR_W'(REG_VALUE):  rdata_nxt = zext(count);
`ifdef WDOG_LOCK_EN
         ADDR_W'(REG_LOCK):   rdata_nxt = {31'b0, locked};
`endif
         default:             rdata_nxt = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         RDATA <= '0;
      end else begin
         RDATA <= rdata_nxt;
      end
   end

endmodule

// File: tb/tb_wdog_timer_core.sv
module tb_wdog_timer_core;

   localparam int RST_PULSE = 16;
   localparam logic [31:0] KEY = 32'h1ACCE551;

   logic        CLK = 1'b0;
   logic        RESETn, TICK, KICK, WRITE;
   logic [3:0]  ADDR;
   logic [31:0] WDATA, RDATA;
   logic        WDOG_INT, WDOG_RST;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   wdog_timer_core #(.WIDTH(32), .ADDR_W(4), .RST_PULSE(RST_PULSE)) dut (
      .CLK      (CLK),
      .RESETn   (RESETn),
      .TICK     (TICK),
      .KICK     (KICK),
      .WRITE    (WRITE),
      .ADDR     (ADDR),
      .WDATA    (WDATA),
      .RDATA    (RDATA),
      .WDOG_INT (WDOG_INT),
      .WDOG_RST (WDOG_RST)
   );

   // Reference model: watchdog described by its modes and a remaining-time
   // countdown for the reset pulse.
   localparam int M_IDLE = 0, M_RUN = 1, M_PEND = 2, M_RST = 3;
   int          m_mode;
   int          m_rst_left;
   logic [31:0] m_load, m_count, m_rdata;
   logic        m_en, m_resen, m_int, m_locked;

   task automatic model_reset();
      m_mode = M_IDLE; m_rst_left = 0;
      m_load = 32'hFFFFFFFF; m_count = 32'hFFFFFFFF; m_rdata = 0;
      m_en = 0; m_resen = 0; m_int = 0; m_locked = 0;
   endtask

   task automatic model_clock();
      logic [31:0] rd, nl;
      logic svc, lw, cw, ok;
      ok = 1'b1;
`ifdef WDOG_LOCK_EN
      ok = !m_locked;
`endif
      case (ADDR)
         4'h0: rd = {29'b0, (m_mode == M_RST), m_int, m_en};
         4'h1: rd = m_load;
         4'h2: rd = {30'b0, m_resen, m_en};
         4'h4: rd = m_count;
`ifdef WDOG_LOCK_EN
         4'hC: rd = {31'b0, m_locked};
`endif
         default: rd = 0;
      endcase
      svc = KICK || (WRITE && ADDR == 4'h3 && ok);
      lw  = WRITE && ADDR == 4'h1 && ok;
      cw  = WRITE && ADDR == 4'h2 && ok;
      nl  = (WDATA == 0) ? 32'd1 : WDATA;
      if (m_mode == M_RST) begin
         m_rst_left--;
         if (m_rst_left == 0) begin
            m_int = 0; m_count = m_load; m_mode = m_en ? M_RUN : M_IDLE;
         end
      end else if (m_mode == M_IDLE) begin
         if (m_en) begin m_mode = M_RUN; m_count = m_load; end
         else if (svc) m_count = m_load;
      end else if (!m_en) begin
         m_mode = M_IDLE; m_int = 0;
         if (svc) m_count = m_load;
      end else if (svc) begin
         m_count = m_load; m_int = 0; m_mode = M_RUN;
      end else if (!lw && TICK) begin
         if (m_count == 1) begin
            m_count = m_load;
            if (m_mode == M_RUN) begin
               m_mode = M_PEND; m_int = 1;
            end else if (m_resen) begin
               m_mode = M_RST; m_rst_left = RST_PULSE;
            end
         end else begin
            m_count = m_count - 1;
         end
      end
      if (lw) begin m_load = nl; m_count = nl; end
      if (cw) begin m_en = WDATA[0]; m_resen = WDATA[1]; end
`ifdef WDOG_LOCK_EN
      if (WRITE && ADDR == 4'hC) m_locked = (WDATA != KEY);
`endif
      m_rdata = rd;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_clock();
      #1;
      check("model_rdata", RDATA, m_rdata);
      check("model_int", {31'b0, WDOG_INT}, {31'b0, m_int});
      check("model_rst", {31'b0, WDOG_RST}, {31'b0, (m_mode == M_RST)});
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      WRITE = 1; ADDR = a; WDATA = d;
      step();
      WRITE = 0; WDATA = 0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      ADDR = a;
      step();
      d = RDATA;
   endtask

   task automatic tick1();
      TICK = 1;
      step();
      TICK = 0;
   endtask

   logic [31:0] v;
   int hi;

   initial begin
      RESETn = 0; TICK = 0; KICK = 0; WRITE = 0; ADDR = 0; WDATA = 0;
      model_reset();
      #12;
      // Test 1: reset state and readback latency
      check("reset_rdata", RDATA, 32'h0);
      check("reset_int", {31'b0, WDOG_INT}, 32'h0);
      check("reset_rst", {31'b0, WDOG_RST}, 32'h0);
      @(negedge CLK);
      RESETn = 1;
      rd(4'h0, v); check("t1_status", v, 32'h0);
      rd(4'h4, v); check("t1_value", v, 32'hFFFFFFFF);

      // Test 2: first expiry and KICK
      wr(4'h1, 5);
      wr(4'h2, 1);
      step();
      for (int i = 0; i < 5; i++) tick1();
      check("t2_int_set", {31'b0, WDOG_INT}, 32'h1);
      rd(4'h4, v); check("t2_value", v, 32'd5);
      KICK = 1; step(); KICK = 0;
      check("t2_int_clr", {31'b0, WDOG_INT}, 32'h0);

      // Test 3: second expiry with RESEN -> reset pulse
      wr(4'h1, 3);
      wr(4'h2, 3);
      for (int i = 0; i < 6; i++) tick1();
      check("t3_rst_start", {31'b0, WDOG_RST}, 32'h1);
      hi = 1;
      for (int g = 0; g < 40 && WDOG_RST; g++) begin
         step();
         if (WDOG_RST) hi++;
      end
      check("t3_rst_width", hi, RST_PULSE);
      check("t3_int_after", {31'b0, WDOG_INT}, 32'h0);
      rd(4'h4, v); check("t3_value", v, 32'd3);
      rd(4'h0, v); check("t3_status", v, 32'h1);

      // Test 4: KICK coincident with expiring TICK; LOAD of zero
      wr(4'h1, 2);
      wr(4'h2, 1);
      tick1();
      TICK = 1; KICK = 1; step(); TICK = 0; KICK = 0;
      check("t4_no_int", {31'b0, WDOG_INT}, 32'h0);
      rd(4'h4, v); check("t4_value", v, 32'd2);
      wr(4'h1, 0);
      rd(4'h1, v); check("t4_load0", v, 32'd1);

      // Test 5: disable during INT_PEND freezes the count
      wr(4'h1, 4);
      for (int i = 0; i < 4; i++) tick1();
      check("t5_int_set", {31'b0, WDOG_INT}, 32'h1);
      tick1();
      wr(4'h2, 0);
      step();
      check("t5_int_clr", {31'b0, WDOG_INT}, 32'h0);
      for (int i = 0; i < 3; i++) tick1();
      rd(4'h4, v); check("t5_frozen", v, 32'd3);

      // Test 5b: asynchronous reset mid-pulse
      wr(4'h1, 1);
      wr(4'h2, 3);
      step();
      tick1();
      tick1();
      check("t5_rst_on", {31'b0, WDOG_RST}, 32'h1);
      step(); step(); step();
      #2 RESETn = 0;
      #1;
      check("t5_async_rst", {31'b0, WDOG_RST}, 32'h0);
      check("t5_async_int", {31'b0, WDOG_INT}, 32'h0);
      model_reset();
      @(negedge CLK);
      RESETn = 1;
      rd(4'h4, v); check("t5_value_rst", v, 32'hFFFFFFFF);

`ifdef WDOG_LOCK_EN
      // Test 6: lock register
      wr(4'h1, 6);
      wr(4'h2, 1);
      step();
      tick1(); tick1();
      wr(4'hC, 0);
      wr(4'h1, 9);
      rd(4'h1, v); check("t6_locked_load", v, 32'd6);
      KICK = 1; step(); KICK = 0;
      rd(4'h4, v); check("t6_kick_locked", v, 32'd6);
      rd(4'hC, v); check("t6_lock_rd1", v, 32'd1);
      wr(4'hC, KEY);
      rd(4'hC, v); check("t6_lock_rd0", v, 32'd0);
      wr(4'h1, 9);
      rd(4'h1, v); check("t6_unlocked_load", v, 32'd9);
`else
      wr(4'hC, 0);
      rd(4'hC, v); check("t6_unmapped", v, 32'd0);
`endif

      // Randomized phase against the model
      for (int n = 0; n < 2500; n++) begin
         TICK  = 1'($urandom_range(0, 1));
         KICK  = ($urandom_range(0, 15) == 0);
         WRITE = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 6))
            0: ADDR = 4'h0;
            1: ADDR = 4'h1;
            2: ADDR = 4'h2;
            3: ADDR = 4'h3;
            4: ADDR = 4'h4;
            5: ADDR = 4'hC;
            default: ADDR = 4'h7;
         endcase
         WDATA = $urandom_range(0, 6);
         if (ADDR == 4'h2) WDATA = ($urandom_range(0, 7) == 0) ? 32'd2 : 32'd3;
         if (ADDR == 4'hC && $urandom_range(0, 1) == 1) WDATA = KEY;
         step();
      end
      TICK = 0; KICK = 0; WRITE = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
